// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load-use and branch-shadow stalls, memory wait/timeout FSM.
// Optional feature macro HAZARD_STATS_EN adds saturating stall_cycles / flush_count statistics outputs.

module pipeline_hazard_unit #(
    parameter int RA_W        = 4,
    parameter int PC_REG      = 15,
    parameter int BR_SHADOW   = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] ra1_d,
    input  logic [RA_W-1:0] ra2_d,
    input  logic [RA_W-1:0] wa3_d,
    input  logic            pcsrc_d,
    input  logic            mem_to_reg_e,
    input  logic            branch_taken_e,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    input  logic            mem_busy,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_em,
    output logic            flush_d,
    output logic            flush_e,
    output logic            mem_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    localparam int CNT_W  = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);
    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [RA_W-1:0]   PC_IDX      = RA_W'(PC_REG);
    localparam logic [CNT_W-1:0]  SHADOW_INIT = CNT_W'(BR_SHADOW);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT  = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BRANCH  = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t            state_r, ret_state_r, shadow_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic [RA_W-1:0]   ra1_e_r, ra2_e_r, wa3_e_r, wa3_m_r, wa3_w_r;
    logic              v_e_r, v_m_r, v_w_r;
    logic              mem_timeout_r;
    logic              lw_s, held_s;
    logic              stall_f_s, stall_d_s, stall_em_s, flush_d_s, flush_e_s;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] ra,
        input logic            src_valid,
        input logic            m_live,
        input logic [RA_W-1:0] m_dst,
        input logic            w_live,
        input logic [RA_W-1:0] w_dst
    );
        logic [1:0] sel;
        if (!src_valid || (ra == PC_IDX)) begin
            sel = 2'b00;
        end else if (m_live && (m_dst == ra)) begin
            sel = 2'b10;
        end else if (w_live && (w_dst == ra)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and hazard detection from the execute-stage tags
    always_comb begin
        forward_a_e = fwd_sel(ra1_e_r, v_e_r, v_m_r & reg_write_m, wa3_m_r, v_w_r & reg_write_w, wa3_w_r);
        forward_b_e = fwd_sel(ra2_e_r, v_e_r, v_m_r & reg_write_m, wa3_m_r, v_w_r & reg_write_w, wa3_w_r);
        lw_s   = mem_to_reg_e & v_e_r & ((ra1_d == wa3_e_r) | (ra2_d == wa3_e_r));
        held_s = (state_r == ST_MEMWAIT) || (state_r == ST_ERROR);
        if ((cnt_r == CNT_W'(1)) && !stall_d_s) begin
            shadow_next_s = ST_RUN;
        end else begin
            shadow_next_s = ST_BRANCH;
        end
    end

    // Stall/flush arbitration: memory wait beats a taken branch, which beats load-use, which beats the shadow
    always_comb begin
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        stall_em_s = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        if (held_s) begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_em_s = 1'b1;
        end else if (branch_taken_e) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (lw_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (state_r == ST_BRANCH) begin
            stall_f_s = 1'b1;
            flush_d_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    assign stall_f     = stall_f_s;
    assign stall_d     = stall_d_s;
    assign stall_em    = stall_em_s;
    assign flush_d     = flush_d_s;
    assign flush_e     = flush_e_s;
    assign mem_timeout = mem_timeout_r;

    // Register-tag pipeline E -> M -> W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1_e_r <= {RA_W{1'b0}};
            ra2_e_r <= {RA_W{1'b0}};
            wa3_e_r <= {RA_W{1'b0}};
            wa3_m_r <= {RA_W{1'b0}};
            wa3_w_r <= {RA_W{1'b0}};
            v_e_r   <= 1'b0;
            v_m_r   <= 1'b0;
            v_w_r   <= 1'b0;
        end else if (!stall_em_s) begin
            wa3_m_r <= wa3_e_r;
            v_m_r   <= v_e_r;
            wa3_w_r <= wa3_m_r;
            v_w_r   <= v_m_r;
            if (flush_e_s) begin
                v_e_r <= 1'b0;
            end else if (!stall_d_s) begin
                ra1_e_r <= ra1_d;
                ra2_e_r <= ra2_d;
                wa3_e_r <= wa3_d;
                v_e_r   <= 1'b1;
            end
        end
    end

    // Branch-shadow / memory-wait FSM; a wait remembers where the pipeline was heading
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            ret_state_r   <= ST_RUN;
            cnt_r         <= {CNT_W{1'b0}};
            wcnt_r        <= {WCNT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pcsrc_d && !stall_d_s) begin
                        cnt_r <= SHADOW_INIT;
                        if (mem_busy) begin
                            state_r     <= ST_MEMWAIT;
                            ret_state_r <= ST_BRANCH;
                            wcnt_r      <= WCNT_W'(1);
                        end else begin
                            state_r <= ST_BRANCH;
                        end
                    end else if (mem_busy) begin
                        state_r     <= ST_MEMWAIT;
                        ret_state_r <= ST_RUN;
                        wcnt_r      <= WCNT_W'(1);
                    end
                end
                ST_BRANCH: begin
                    if (!stall_d_s) begin
                        cnt_r <= (cnt_r == CNT_W'(1)) ? {CNT_W{1'b0}} : (cnt_r - CNT_W'(1));
                    end
                    if (mem_busy) begin
                        state_r     <= ST_MEMWAIT;
                        ret_state_r <= shadow_next_s;
                        wcnt_r      <= WCNT_W'(1);
                    end else begin
                        state_r <= shadow_next_s;
                    end
                end
                ST_MEMWAIT: begin
                    if (!mem_busy) begin
                        state_r <= ret_state_r;
                    end else if (wcnt_r == WAIT_LIMIT) begin
                        state_r       <= ST_ERROR;
                        mem_timeout_r <= 1'b1;
                    end else begin
                        wcnt_r <= wcnt_r + WCNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    mem_timeout_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_r, flush_count_r;

    // Saturating statistics counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            if (stall_f_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (flush_e_s && (flush_count_r != 32'hFFFF_FFFF)) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed scenarios plus randomized traffic against a
// behavioural model that tracks instructions in E/M/W, a remaining-shadow count and a wait/error mode.

module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ra1_d, ra2_d, wa3_d;
    logic       pcsrc_d, mem_to_reg_e, branch_taken_e, reg_write_m, reg_write_w, mem_busy;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, stall_em, flush_d, flush_e, mem_timeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
        .pcsrc_d(pcsrc_d), .mem_to_reg_e(mem_to_reg_e), .branch_taken_e(branch_taken_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .mem_busy(mem_busy),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
        .flush_d(flush_d), .flush_e(flush_e), .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [3:0] rd;
    } instr_t;

    instr_t pe, pm, pw;
    int     shadow_left, wait_len;
    bit     waiting, errored;
    int     exp_stalls, exp_flushes;
    int     n_cmp = 0, n_err = 0, cyc = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [3:0] r, input logic rwm, input logic rww);
        if (!pe.v || r == 4'd15) return 2'd0;
        if (pm.v && rwm && pm.rd == r) return 2'd2;
        if (pw.v && rww && pw.rd == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic void model_reset();
        pe = '{1'b0, 4'd0, 4'd0, 4'd0};
        pm = pe;
        pw = pe;
        shadow_left = 0;
        wait_len    = 0;
        waiting     = 1'b0;
        errored     = 1'b0;
        exp_stalls  = 0;
        exp_flushes = 0;
    endfunction

    // One clock: drive at the falling edge, check before the rising edge, then advance the model.
    task automatic step(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] d,
                        input logic pc, input logic mtr, input logic bt,
                        input logic rwm, input logic rww, input logic busy);
        logic lw, esf, esd, esem, efd, efe;
        @(negedge clk);
        cyc++;
        ra1_d = a1; ra2_d = a2; wa3_d = d;
        pcsrc_d = pc; mem_to_reg_e = mtr; branch_taken_e = bt;
        reg_write_m = rwm; reg_write_w = rww; mem_busy = busy;
        #1;
        lw = mtr && pe.v && (a1 == pe.rd || a2 == pe.rd);
        {esf, esd, esem, efd, efe} = 5'b00000;
        if (waiting || errored) {esf, esd, esem} = 3'b111;
        else if (bt)             {efd, efe} = 2'b11;
        else if (lw)             {esf, esd, efe} = 3'b111;
        else if (shadow_left > 0) {esf, efd} = 2'b11;
        check_value("fwd", 32'({forward_a_e, forward_b_e}), 32'({model_fwd(pe.r1, rwm, rww), model_fwd(pe.r2, rwm, rww)}));
        check_value("ctl", 32'({stall_f, stall_d, stall_em, flush_d, flush_e, mem_timeout}),
                    32'({esf, esd, esem, efd, efe, errored}));
`ifdef HAZARD_STATS_EN
        check_value("stall_cycles", stall_cycles, 32'(exp_stalls));
        check_value("flush_count", flush_count, 32'(exp_flushes));
`endif
        if (esf) exp_stalls++;
        if (efe) exp_flushes++;
        if (errored) begin
            errored = 1'b1;
        end else if (waiting) begin
            if (!busy) waiting = 1'b0;
            else if (wait_len == 15) errored = 1'b1;
            else wait_len++;
        end else begin
            if (shadow_left > 0) begin
                if (!esd) shadow_left--;
            end else if (pc && !esd) begin
                shadow_left = 3;
            end
            if (busy) begin
                waiting  = 1'b1;
                wait_len = 1;
            end
            pw = pm;
            pm = pe;
            if (efe) pe.v = 1'b0;
            else if (!esd) pe = '{1'b1, a1, a2, d};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        {ra1_d, ra2_d, wa3_d} = 12'd0;
        {pcsrc_d, mem_to_reg_e, branch_taken_e, reg_write_m, reg_write_w, mem_busy} = 6'd0;
        #1;
        check_value("rst_fwd", 32'({forward_a_e, forward_b_e}), 32'd0);
        check_value("rst_ctl", 32'({stall_f, stall_d, stall_em, flush_d, flush_e, mem_timeout}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic logic [3:0] rreg();
        int x = $urandom_range(0, 5);
        return (x == 5) ? 4'd15 : 4'(x);
    endfunction

    int cnt_a, cnt_b, busy_left;
    logic bsy;

    initial begin
        reset = 1'b0;
        {ra1_d, ra2_d, wa3_d} = 12'd0;
        {pcsrc_d, mem_to_reg_e, branch_taken_e, reg_write_m, reg_write_w, mem_busy} = 6'd0;
        model_reset();
        do_reset();

        // forwarding: M match, W-only match, M beats W, PC never forwarded
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 6, 0, 0, 0, 1, 0, 0);
        check_value("fwd_m", 32'(forward_a_e), 32'd2);
        step(0, 0, 4, 0, 0, 0, 0, 0, 0);
        step(0, 0, 7, 0, 0, 0, 0, 0, 0);
        step(0, 4, 8, 0, 0, 0, 0, 0, 0);
        step(0, 0, 9, 0, 0, 0, 1, 1, 0);
        check_value("fwd_w", 32'(forward_b_e), 32'd1);
        step(0, 0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0, 0, 0, 0);
        step(2, 0, 9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 8, 0, 0, 0, 1, 1, 0);
        check_value("fwd_mw", 32'(forward_a_e), 32'd2);
        step(0, 0, 15, 0, 0, 0, 0, 0, 0);
        step(15, 0, 9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 8, 0, 0, 0, 1, 1, 0);
        check_value("fwd_pc", 32'(forward_a_e), 32'd0);

        // load-use: one stall cycle, then forward from writeback
        step(0, 0, 3, 0, 0, 0, 0, 0, 0);
        step(3, 0, 10, 0, 1, 0, 0, 0, 0);
        check_value("lu_stall", 32'({stall_f, stall_d, flush_e}), 32'b111);
        step(3, 0, 10, 0, 0, 0, 0, 0, 0);
        check_value("lu_once", 32'(stall_d), 32'd0);
        step(0, 0, 11, 0, 0, 0, 0, 1, 0);
        check_value("lu_fwd", 32'(forward_a_e), 32'd1);

        // branch shadow of exactly three cycles
        do_reset();
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (stall_f && flush_d) cnt_a++;
        end
        check_value("shadow_len", 32'(cnt_a), 32'd3);

        // four busy cycles during the shadow: four waiting cycles, shadow resumes
        do_reset();
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cnt_a = 0; cnt_b = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, (i < 4) ? 1'b1 : 1'b0);
            if (stall_em) cnt_a++;
            if (flush_d) cnt_b++;
        end
        check_value("wait_len", 32'(cnt_a), 32'd4);
        check_value("shadow_total", 32'(cnt_b), 32'd3);

        // timeout boundary: 15 busy cycles recover, 16 trip the sticky error
        do_reset();
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_value("no_timeout", 32'({mem_timeout, stall_em}), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_value("timeout", 32'({mem_timeout, stall_em}), 32'b11);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0);
        check_value("timeout_sticky", 32'({mem_timeout, stall_f, flush_e}), 32'b110);
        do_reset();

`ifdef HAZARD_STATS_EN
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 0, 0, 0, 0, 0, 0);
        step(3, 0, 4, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_value("stats_stall", stall_cycles, 32'd4);
        check_value("stats_flush", flush_count, 32'd1);
        do_reset();
`endif

        // randomized traffic against the model
        busy_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if (busy_left == 0 && $urandom_range(0, 24) == 0) busy_left = $urandom_range(1, 18);
            bsy = (busy_left > 0);
            if (bsy) busy_left--;
            step(rreg(), rreg(), rreg(),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bsy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
